// File: rtl/lstm_fwd_cell.sv
// lstm_fwd_cell: forward LSTM cell, c = at*it + ft*c_prev, h = ot*tanh_pl(c), one shared multiplier and adder
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_valid/i_ready   input handshake (ready only in IDLE)
//   i_first           first timestep, previous state treated as 0
//   at, it, ft, ot    activated gate values, signed Q(WIDTH-FRAC).FRAC
//   o_valid/o_ready   output handshake (valid only in DONE)
//   o_state           new cell state c
//   o_tanh            tanh_pl(c)
//   o_h               ot * tanh_pl(c)
module lstm_fwd_cell #(
   parameter int WIDTH = 32,
   parameter int FRAC  = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic             i_first,
   input  logic [WIDTH-1:0] at,
   input  logic [WIDTH-1:0] it,
   input  logic [WIDTH-1:0] ft,
   input  logic [WIDTH-1:0] ot,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [WIDTH-1:0] o_state,
   output logic [WIDTH-1:0] o_tanh,
   output logic [WIDTH-1:0] o_h
);
   typedef enum logic [2:0] {IDLE, MUL_AI, MUL_FC, ADD, TANH, MUL_OH, DONE} state_t;
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1) << FRAC;
   localparam logic [WIDTH-1:0] HALF = ONE >> 1;
   localparam logic [WIDTH-1:0] QTR  = ONE >> 2;
   localparam logic [WIDTH-1:0] KNEE = ONE + HALF;
   state_t r_st, w_nxt;
   logic [WIDTH-1:0] r_at, r_it, r_ft, r_ot, r_p1, r_p2, r_c, r_th, r_h;
   logic r_first;
   logic [WIDTH-1:0] w_mul_a, w_mul_b, w_mul, w_abs, w_add_a, w_add_b, w_sum, w_mag, w_th;
   logic signed [2*WIDTH-1:0] w_ea, w_eb;
   logic w_neg;
   // shared multiplier operand selection
   assign w_mul_a = r_st == MUL_AI ? r_at : r_st == MUL_FC ? r_ft : r_ot;
   assign w_mul_b = r_st == MUL_AI ? r_it : r_st == MUL_FC ? r_c : r_th;
   assign w_ea    = {{WIDTH{w_mul_a[WIDTH-1]}}, w_mul_a};
   assign w_eb    = {{WIDTH{w_mul_b[WIDTH-1]}}, w_mul_b};
   assign w_mul   = WIDTH'((w_ea * w_eb) >>> FRAC);
   // tanh_pl works on |c| as unsigned; the most-negative c has |c| = 2^(WIDTH-1),
   // which lands in the saturated segment and re-signs to -1.0
   assign w_neg   = r_c[WIDTH-1];
   assign w_abs   = w_neg ? -r_c : r_c;
   // shared adder: p1+p2 in ADD, |c|/2 + 0.25 in TANH
   assign w_add_a = r_st == ADD ? r_p1 : w_abs >> 1;
   assign w_add_b = r_st == ADD ? r_p2 : QTR;
   assign w_sum   = w_add_a + w_add_b;
   assign w_mag   = w_abs < HALF ? w_abs : w_abs < KNEE ? w_sum : ONE;
   assign w_th    = w_neg ? -w_mag : w_mag;
   assign i_ready = r_st == IDLE;
   assign o_valid = r_st == DONE;
   assign o_state = r_c;
   assign o_tanh  = r_th;
   assign o_h     = r_h;
   always_comb begin
      w_nxt = r_st;
      case (r_st)
         IDLE:    w_nxt = i_valid ? MUL_AI : IDLE;
         MUL_AI:  w_nxt = MUL_FC;
         MUL_FC:  w_nxt = ADD;
         ADD:     w_nxt = TANH;
         TANH:    w_nxt = MUL_OH;
         MUL_OH:  w_nxt = DONE;
         DONE:    w_nxt = o_ready ? IDLE : DONE;
         default: w_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_st    <= IDLE;
         r_at    <= '0;
         r_it    <= '0;
         r_ft    <= '0;
         r_ot    <= '0;
         r_first <= 1'b0;
         r_p1    <= '0;
         r_p2    <= '0;
         r_c     <= '0;
         r_th    <= '0;
         r_h     <= '0;
      end else begin
         r_st <= w_nxt;
         if (r_st == IDLE && i_valid) begin
            r_at    <= at;
            r_it    <= it;
            r_ft    <= ft;
            r_ot    <= ot;
            r_first <= i_first;
         end
         if (r_st == MUL_AI) r_p1 <= w_mul;
         if (r_st == MUL_FC) r_p2 <= r_first ? '0 : w_mul;
         if (r_st == ADD) r_c <= w_sum;
         if (r_st == TANH) r_th <= w_th;
         if (r_st == MUL_OH) r_h <= w_mul;
      end
   end
endmodule

// File: tb/tb_lstm_fwd_cell.sv
// tb_lstm_fwd_cell: directed bench for lstm_fwd_cell with an arithmetic reference model
module tb_lstm_fwd_cell;
   localparam int W = 32;
   localparam int F = 24;
   logic clk = 1'b0, rst = 1'b1, i_valid = 1'b0, i_first = 1'b0, o_ready = 1'b0;
   logic [W-1:0] at_r = '0, it_r = '0, ft_r = '0, ot_r = '0;
   logic i_ready, o_valid;
   logic [W-1:0] o_state, o_tanh, o_h;
   int checks = 0, errors = 0;
   logic [W-1:0] m_c = '0, m_state = '0, m_tanh = '0, m_h = '0;
   bit armed = 1'b0;
   logic [W-1:0] s_state, s_tanh, s_h;

   lstm_fwd_cell #(.WIDTH(W), .FRAC(F)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_first(i_first),
      .at(at_r), .it(it_r), .ft(ft_r), .ot(ot_r),
      .o_valid(o_valid), .o_ready(o_ready),
      .o_state(o_state), .o_tanh(o_tanh), .o_h(o_h)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   function automatic logic [W-1:0] fmul(input logic [W-1:0] a, input logic [W-1:0] b);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      return W'(p >>> F);
   endfunction

   function automatic logic [W-1:0] ftanh(input logic [W-1:0] x);
      longint v, a, r;
      v = longint'($signed(x));
      a = v < 0 ? -v : v;
      if (a < 64'sh0080_0000) r = a;
      else if (a < 64'sh0180_0000) r = a / 2 + 64'sh0040_0000;
      else r = 64'sh0100_0000;
      return W'(v < 0 ? -r : r);
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic model_accept(input logic [W-1:0] a, i, f, o, input bit first);
      m_state = fmul(a, i) + (first ? '0 : fmul(f, m_c));
      m_c     = m_state;
      m_tanh  = ftanh(m_state);
      m_h     = fmul(o, m_tanh);
      armed   = 1'b1;
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!o_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("latency", n, 5);
   endtask

   task automatic send(input logic [W-1:0] a, i, f, o, input bit first);
      int n = 0;
      @(negedge clk);
      while (!i_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!i_ready) chk("ready_timeout", {31'b0, i_ready}, 1);
      at_r = a; it_r = i; ft_r = f; ot_r = o; i_first = first; i_valid = 1'b1;
      @(posedge clk);
      #1 i_valid = 1'b0;
      model_accept(a, i, f, o, first);
      wait_valid();
   endtask

   task automatic handshake();
      @(negedge clk) o_ready = 1'b1;
      @(posedge clk);
      #1 o_ready = 1'b0;
      armed = 1'b0;
      chk("valid_after_hs", {31'b0, o_valid}, 0);
      chk("ready_after_hs", {31'b0, i_ready}, 1);
   endtask

   // every cycle with a result on the outputs must match the model
   always @(negedge clk) begin
      if (!rst && o_valid) begin
         if (!armed) chk("spurious_valid", {31'b0, o_valid}, 0);
         else begin
            chk("cmp_state", o_state, m_state);
            chk("cmp_tanh", o_tanh, m_tanh);
            chk("cmp_h", o_h, m_h);
            chk("cmp_iready", {31'b0, i_ready}, 0);
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", o_state, 0);
      chk("rst_tanh", o_tanh, 0);
      chk("rst_h", o_h, 0);
      chk("rst_ovalid", {31'b0, o_valid}, 0);
      chk("rst_iready", {31'b0, i_ready}, 1);
      @(negedge clk) rst = 1'b0;

      send(32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 32'h0100_0000, 1'b1);
      chk("t1_state", o_state, 32'h0040_0000);
      chk("t1_tanh", o_tanh, 32'h0040_0000);
      chk("t1_h", o_h, 32'h0040_0000);
      handshake();

      send(32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 1'b0);
      chk("t2_state", o_state, 32'h0060_0000);
      chk("t2_tanh", o_tanh, 32'h0060_0000);
      chk("t2_h", o_h, 32'h0030_0000);
      handshake();

      send(32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 1'b0);
      chk("t3_state", o_state, 32'h0160_0000);
      chk("t3_tanh", o_tanh, 32'h00F0_0000);
      chk("t3_h", o_h, 32'h00F0_0000);
      handshake();

      send(32'hFF00_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 1'b1);
      chk("t4_state", o_state, 32'hFF00_0000);
      chk("t4_tanh", o_tanh, 32'hFF40_0000);
      chk("t4_h", o_h, 32'hFF40_0000);
      handshake();

      send(32'hFE00_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 1'b0);
      chk("t5_state", o_state, 32'hFD00_0000);
      chk("t5_tanh", o_tanh, 32'hFF00_0000);
      handshake();

      send(32'h0040_0000, 32'h0100_0000, 32'h0080_0000, 32'h0100_0000, 1'b0);
      s_state = o_state; s_tanh = o_tanh; s_h = o_h;
      @(negedge clk);
      at_r = 32'h0100_0000; it_r = 32'h0040_0000; ft_r = 32'h0; ot_r = 32'h0100_0000;
      i_first = 1'b1; i_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         chk("bp_valid", {31'b0, o_valid}, 1);
         chk("bp_iready", {31'b0, i_ready}, 0);
         chk("bp_state", o_state, s_state);
         chk("bp_tanh", o_tanh, s_tanh);
         chk("bp_h", o_h, s_h);
      end
      @(negedge clk) o_ready = 1'b1;
      @(posedge clk);
      #1 o_ready = 1'b0;
      armed = 1'b0;
      chk("bp_hs_valid", {31'b0, o_valid}, 0);
      chk("bp_hs_iready", {31'b0, i_ready}, 1);
      chk("bp_hs_state", o_state, s_state);
      @(posedge clk);
      #1 i_valid = 1'b0;
      chk("bp_accept", {31'b0, i_ready}, 0);
      model_accept(32'h0100_0000, 32'h0040_0000, 32'h0, 32'h0100_0000, 1'b1);
      wait_valid();
      chk("bp_new_state", o_state, 32'h0040_0000);
      handshake();

      send(32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 1'b0);
      handshake();

      @(negedge clk);
      at_r = 32'h0100_0000; it_r = 32'h0100_0000; ft_r = 32'h0100_0000; ot_r = 32'h0100_0000;
      i_first = 1'b0; i_valid = 1'b1;
      @(posedge clk);
      #1 i_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mr_state", o_state, 0);
      chk("mr_tanh", o_tanh, 0);
      chk("mr_h", o_h, 0);
      chk("mr_ovalid", {31'b0, o_valid}, 0);
      chk("mr_iready", {31'b0, i_ready}, 1);
      armed = 1'b0;
      m_c = '0;
      @(negedge clk) rst = 1'b0;
      repeat (8) @(posedge clk);
      #1 chk("mr_no_valid", {31'b0, o_valid}, 0);

      send(32'h0080_0000, 32'h0080_0000, 32'h0100_0000, 32'h0100_0000, 1'b0);
      chk("mr_after_state", o_state, 32'h0040_0000);
      handshake();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/lstm_fwd_cell.md
# lstm_fwd_cell

Forward-pass LSTM cell datapath: takes activated gate values for one timestep, computes the new cell state and the cell output, and keeps the state internally for the next timestep. It produces the `state`/`h` values that the backward delta stage consumes. It is time-multiplexed around one multiplier and one adder, sequenced by an FSM, with valid/ready handshakes on both sides. Number format is signed fixed point Q(WIDTH−FRAC).FRAC; 1.0 = `0x01000000` at the default parameters.

## Interface

- `WIDTH`, 32: data word width.
- `FRAC`, 24: fractional bits.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `i_valid`  in  1  input operands valid.
- `i_ready`  out  1  block can accept an input; high only in IDLE.
- `i_first`  in  1  first timestep of a sequence; previous state is treated as 0.
- `at`, `it`, `ft`, `ot`  in  WIDTH  candidate, input, forget and output gate values (already activated).
- `o_valid`  out  1  result valid.
- `o_ready`  in  1  downstream accepts the result.
- `o_state`  out  WIDTH  new cell state c = at·it + ft·c_prev.
- `o_tanh`  out  WIDTH  tanh_pl(c).
- `o_h`  out  WIDTH  h = ot·tanh_pl(c).

## Operation

- **FSM states:** IDLE → MUL_AI → MUL_FC → ADD → TANH → MUL_OH → DONE → IDLE.
- **IDLE:** `i_ready`=1. When `i_valid` is high at an edge, the block registers `at`, `it`, `ft`, `ot` and `i_first`, then moves to MUL_AI.
- **MUL_AI:** p1 ← at·it.
- **MUL_FC:** p2 ← ft·c_prev. If the captured `i_first`=1, p2 ← 0.
- **ADD:** c ← p1 + p2. c_prev ← the same value.
- **TANH:** th ← tanh_pl(c).
- **MUL_OH:** h ← ot·th.
- **DONE:** `o_valid`=1. The block stays in DONE until `o_ready` is high at an edge, then returns to IDLE.
- **Multiply:** full signed 2·WIDTH product, arithmetic shift right by FRAC, keep the low WIDTH bits. No rounding, no saturation.
- **Add:** WIDTH-bit two's-complement, wraps on overflow.
- **tanh_pl(x):** odd-symmetric piecewise-linear function, computed on a = |x| and then re-signed.
  - a < 0.5 → a.
  - 0.5 ≤ a < 1.5 → (a>>>1) + 0.25.
  - a ≥ 1.5 → 1.0.
  - x = most-negative value → −1.0.
- **Output registers:**
  - `o_state`, `o_tanh` and `o_h` are registers.
  - They update only in their own compute state and hold otherwise, including after the output handshake and through IDLE.
- **c_prev:** persists across transactions and changes only in ADD or on reset.
- The only multiplier is shared by MUL_AI, MUL_FC and MUL_OH. The only adder is shared by ADD and the tanh_pl offset.

## Timing

- **Reset values:** all outputs, internal registers and c_prev are 0. FSM is in IDLE, so `i_ready`=1 and `o_valid`=0.
- **Latency:** accept at edge E0 → `o_valid` rises after edge E0+5.
  - `o_state` is valid after E0+3.
  - `o_tanh` is valid after E0+4.
  - `o_h` is valid after E0+5.
- **Throughput:** with `o_ready` tied high, the output handshake occurs at E0+6 and `i_ready` is high again after E0+6. That gives one result per 7 cycles.
- `i_ready` is low in every state except IDLE. While it is low, `i_valid` and the input data are ignored and not buffered.
- **Backpressure:** in DONE, `o_valid` stays high and all outputs are held stable until `o_ready` is sampled high.
- Inputs are sampled only at the accept edge; later changes on `at`…`ot` have no effect.
- **`rst` asserted in any state:** at the next edge the block returns to IDLE, outputs are zeroed, c_prev is cleared, and any in-flight result is discarded.
- **Simultaneous `i_valid` and `o_ready` while in DONE:** only the output handshake completes; the new input is accepted no earlier than the following cycle, from IDLE.

## Test plan

- **Reset then first step:** reset, then at = it = ft = 0x00800000, ot = 0x01000000, `i_first`=1.
  - Required: o_state = 0x00400000, o_tanh = 0x00400000, o_h = 0x00400000.
  - Required: `o_valid` rises exactly 5 cycles after the accept edge.
- **State carry:** next step with the same a/i/f, ot = 0x00800000, `i_first`=0.
  - Required: o_state = 0x00600000, o_tanh = 0x00600000, o_h = 0x00300000.
- **Middle tanh segment:** then at = it = ft = ot = 0x01000000, `i_first`=0.
  - Required: o_state = 0x01600000, o_tanh = 0x00F00000, o_h = 0x00F00000.
- **Negative value and tanh saturation:** `i_first`=1, at = 0xFF000000, it = ot = 0x01000000.
  - Required: o_state = 0xFF000000, o_tanh = 0xFF400000, o_h = 0xFF400000.
  - Then a step with at = 0xFE000000 and it = ft = ot = 0x01000000.
  - Required: o_state = 0xFD000000, o_tanh = 0xFF000000.
- **Backpressure:** hold `o_ready`=0 for 4 cycles in DONE while driving `i_valid`=1 with new data.
  - Required: outputs and `o_valid` stable, `i_ready`=0, no input accepted.
  - Required: after `o_ready`, exactly one handshake occurs and the next accept happens from IDLE.
- **Reset mid-operation:** assert `rst` in TANH.
  - Required: next cycle is IDLE with all outputs 0 and `o_valid` never asserted.
  - Required: a following step with `i_first`=0 computes as if c_prev = 0.
